// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - buffered XY beam sequencer with DAC and line-generator handshakes
module vector_sequencer #(
  parameter int COORD_W       = 12,
  parameter int FIFO_DEPTH    = 8,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_draw_i,
  input  logic [COORD_W-1:0] cmd_x_i,
  input  logic [COORD_W-1:0] cmd_y_i,
  output logic               busy_o,
  output logic               blank_o,
  output logic [COORD_W-1:0] dac_value_o,
  output logic               dac_axis_o,
  output logic               dac_strobe_o,
  input  logic               dac_ready_i,
  output logic               line_start_o,
  output logic [COORD_W-1:0] line_x0_o,
  output logic [COORD_W-1:0] line_y0_o,
  output logic [COORD_W-1:0] line_x1_o,
  output logic [COORD_W-1:0] line_y1_o,
  input  logic               line_pt_valid_i,
  output logic               line_pt_ready_o,
  input  logic [COORD_W-1:0] line_pt_x_i,
  input  logic [COORD_W-1:0] line_pt_y_i,
  input  logic               line_pt_last_i
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int ENT_W = 2 * COORD_W + 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LSTART, S_LWAIT, S_WRX, S_GAP, S_WRY, S_SETTLE
  } state_t;

  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push, pop;
  logic               head_draw;
  logic [COORD_W-1:0] head_x, head_y;

  state_t             state_q;
  logic [COORD_W-1:0] cur_x_q, cur_y_q, pt_x_q, pt_y_q;
  logic [COORD_W-1:0] dac_value_q, x0_q, y0_q, x1_q, y1_q;
  logic               draw_q, last_q, blank_q, axis_q, line_start_q, pt_ready_q;
  logic [CNT_W-1:0]   settle_q;

  assign cmd_ready_o = (count_q != FULL);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign {head_draw, head_x, head_y} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_draw_i, cmd_x_i, cmd_y_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      pt_x_q       <= '0;
      pt_y_q       <= '0;
      dac_value_q  <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      draw_q       <= 1'b0;
      last_q       <= 1'b0;
      blank_q      <= 1'b1;
      axis_q       <= 1'b0;
      line_start_q <= 1'b0;
      pt_ready_q   <= 1'b0;
      settle_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      line_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pop) begin
          draw_q <= head_draw;
          pt_x_q <= head_x;
          pt_y_q <= head_y;
          if (head_draw) begin
            state_q      <= S_LSTART;
            line_start_q <= 1'b1;
            blank_q      <= 1'b0;
            x0_q         <= cur_x_q;
            y0_q         <= cur_y_q;
            x1_q         <= head_x;
            y1_q         <= head_y;
          end else if (head_x != cur_x_q || head_y != cur_y_q) begin
            state_q     <= S_WRX;
            dac_value_q <= head_x;
            axis_q      <= 1'b0;
          end
        end
        S_LSTART: begin
          state_q    <= S_LWAIT;
          pt_ready_q <= 1'b1;
        end
        S_LWAIT: if (line_pt_valid_i && pt_ready_q) begin
          pt_x_q      <= line_pt_x_i;
          pt_y_q      <= line_pt_y_i;
          last_q      <= line_pt_last_i;
          pt_ready_q  <= 1'b0;
          dac_value_q <= line_pt_x_i;
          axis_q      <= 1'b0;
          state_q     <= S_WRX;
        end
        S_WRX: if (dac_ready_i) state_q <= S_GAP;
        // The DAC drops ready only a cycle after the strobe, so skip that cycle.
        S_GAP: begin
          dac_value_q <= pt_y_q;
          axis_q      <= 1'b1;
          state_q     <= S_WRY;
        end
        S_WRY: if (dac_ready_i) begin
          cur_x_q <= pt_x_q;
          cur_y_q <= pt_y_q;
          if (draw_q) begin
            if (last_q) begin
              state_q <= S_IDLE;
              blank_q <= 1'b1;
            end else begin
              state_q    <= S_LWAIT;
              pt_ready_q <= 1'b1;
            end
          end else if (SETTLE_CYCLES == 0) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_SETTLE;
            settle_q <= CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) state_q <= S_IDLE;
          else                settle_q <= settle_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = (state_q != S_IDLE) || (count_q != '0);
  assign blank_o         = blank_q;
  assign dac_value_o     = dac_value_q;
  assign dac_axis_o      = axis_q;
  assign dac_strobe_o    = ((state_q == S_WRX) || (state_q == S_WRY)) && dac_ready_i;
  assign line_start_o    = line_start_q;
  assign line_x0_o       = x0_q;
  assign line_y0_o       = y0_q;
  assign line_x1_o       = x1_q;
  assign line_y1_o       = y1_q;
  assign line_pt_ready_o = pt_ready_q;
endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - randomized self-checking bench for vector_sequencer
`timescale 1ns/1ps
module tb_vector_sequencer;
  localparam int CW = 12, DEPTH = 8, SETTLE = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_draw = 1'b0;
  logic [CW-1:0] cmd_x = '0, cmd_y = '0;
  logic busy, blank, dac_axis, dac_strobe, dac_ready, line_start, line_pt_ready;
  logic [CW-1:0] dac_value, line_x0, line_y0, line_x1, line_y1;
  logic line_pt_valid, line_pt_last;
  logic [CW-1:0] line_pt_x, line_pt_y;

  vector_sequencer #(.COORD_W(CW), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_draw_i(cmd_draw), .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .busy_o(busy), .blank_o(blank),
    .dac_value_o(dac_value), .dac_axis_o(dac_axis), .dac_strobe_o(dac_strobe),
    .dac_ready_i(dac_ready), .line_start_o(line_start), .line_x0_o(line_x0),
    .line_y0_o(line_y0), .line_x1_o(line_x1), .line_y1_o(line_y1),
    .line_pt_valid_i(line_pt_valid), .line_pt_ready_o(line_pt_ready),
    .line_pt_x_i(line_pt_x), .line_pt_y_i(line_pt_y), .line_pt_last_i(line_pt_last));

  always #5 clk = ~clk;

  typedef struct packed { logic [CW-1:0] x; logic [CW-1:0] y; logic last; } pt_t;

  int n_checks = 0, n_fail = 0;
  int viol_cnt = 0, acc_cnt = 0, strobe_cnt = 0;
  logic stall_dac = 1'b0;
  bit ls_flag = 0, acc_flag = 0, strobe_flag = 0;
  logic [CW-1:0] m_cur_x = '0, m_cur_y = '0;
  logic [CW+1:0] exp_dac[$], got_dac[$];
  logic [4*CW-1:0] exp_ls[$], got_ls[$];
  pt_t gen_q[$];

  function automatic int absdiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int steps(int x0, int y0, int x1, int y1);
    int dx = absdiff(x0, x1), dy = absdiff(y0, y1);
    return (dx > dy) ? dx : dy;
  endfunction

  function automatic logic [CW-1:0] interp(int a, int b, int i, int n);
    if (n == 0) return CW'(b);
    return CW'(a + ((b - a) * i) / n);
  endfunction

  // Observation of the DUT's outgoing traffic.
  always @(negedge clk) begin
    if (!reset) begin
      if (dac_strobe) begin
        if (!dac_ready) viol_cnt++;
        got_dac.push_back({blank, dac_axis, dac_value});
        strobe_cnt++;
        strobe_flag = 1;
      end
      if (line_start) begin
        got_ls.push_back({line_x0, line_y0, line_x1, line_y1});
        ls_flag = 1;
      end
      if (line_pt_valid && line_pt_ready) begin
        acc_cnt++;
        acc_flag = 1;
      end
    end
  end

  // DAC: busy for 1..3 cycles after each strobe, or held off while stalled.
  initial begin
    int hold;
    hold = 0;
    dac_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (strobe_flag) begin strobe_flag = 0; hold = $urandom_range(1, 3); end
      if (hold > 0) begin dac_ready = 1'b0; hold--; end
      else dac_ready = !stall_dac;
    end
  end

  // Line generator: evenly spaced points from start to end inclusive.
  initial begin
    logic [CW-1:0] x0, y0, x1, y1;
    pt_t p;
    int n;
    line_pt_valid = 1'b0; line_pt_x = '0; line_pt_y = '0; line_pt_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        gen_q.delete(); line_pt_valid = 1'b0; ls_flag = 0; acc_flag = 0;
      end else begin
        if (acc_flag) begin acc_flag = 0; void'(gen_q.pop_front()); line_pt_valid = 1'b0; end
        if (ls_flag) begin
          ls_flag = 0;
          {x0, y0, x1, y1} = got_ls[$];
          n = steps(x0, y0, x1, y1);
          for (int i = 0; i <= n; i++) begin
            p.x = interp(x0, x1, i, n); p.y = interp(y0, y1, i, n); p.last = (i == n);
            gen_q.push_back(p);
          end
        end
        if (!line_pt_valid && gen_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          line_pt_valid = 1'b1;
          {line_pt_x, line_pt_y, line_pt_last} = gen_q[0];
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic model_cmd(input logic d, input logic [CW-1:0] x, input logic [CW-1:0] y);
    int n;
    if (!d) begin
      if (x != m_cur_x || y != m_cur_y) begin
        exp_dac.push_back({1'b1, 1'b0, x});
        exp_dac.push_back({1'b1, 1'b1, y});
      end
    end else begin
      exp_ls.push_back({m_cur_x, m_cur_y, x, y});
      n = steps(m_cur_x, m_cur_y, x, y);
      for (int i = 0; i <= n; i++) begin
        exp_dac.push_back({1'b0, 1'b0, interp(m_cur_x, x, i, n)});
        exp_dac.push_back({1'b0, 1'b1, interp(m_cur_y, y, i, n)});
      end
    end
    m_cur_x = x; m_cur_y = y;
  endtask

  task automatic push_cmd(input logic d, input logic [CW-1:0] x, input logic [CW-1:0] y,
                          input int limit, output bit ok);
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_draw = d; cmd_x = x; cmd_y = y;
    ok = 0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (ok) begin @(posedge clk); #2; model_cmd(d, x, y); end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (!busy && gen_q.size() == 0) begin ok = 1; break; end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    got_dac.delete(); exp_dac.delete(); got_ls.delete(); exp_ls.delete();
    m_cur_x = '0; m_cur_y = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, blank, dac_strobe, dac_axis, line_start, line_pt_ready} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 1010000",
               {cmd_ready, busy, blank, dac_strobe, dac_axis, line_start, line_pt_ready});
    end
    n_checks++;
    if ({dac_value, line_x0, line_y0, line_x1, line_y1} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0", {dac_value, line_x0, line_y0, line_x1, line_y1});
    end
  endtask

  task automatic test_null_jump();
    bit ok;
    int s0, low_at;
    s0 = strobe_cnt;
    low_at = -1;
    push_cmd(1'b0, 12'd0, 12'd0, 20, ok);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (!busy && low_at < 0) low_at = t;
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || low_at < 0) begin
      n_fail++;
      $display("FAIL null_jump_busy accepted %0d low_at %0d want busy low within 3", ok, low_at);
    end
    n_checks++;
    if (strobe_cnt != s0) begin
      n_fail++;
      $display("FAIL null_jump_strobes got %0d want 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_jump();
    bit ok;
    int ycyc, fall, unblank;
    got_dac.delete(); exp_dac.delete();
    ycyc = -1; fall = -1; unblank = 0;
    push_cmd(1'b0, 12'd100, 12'd200, 20, ok);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!blank) unblank++;
      if (dac_strobe && dac_axis) ycyc = t;
      if (!busy && ycyc >= 0) begin fall = t; break; end
    end
    n_checks++;
    if (got_dac.size() != 2 || got_dac[0] !== {2'b10, 12'd100} || got_dac[1] !== {2'b11, 12'd200}) begin
      n_fail++;
      $display("FAIL jump_writes got %p want blanked X=100 axis0, Y=200 axis1", got_dac);
    end
    n_checks++;
    if (ycyc < 0 || fall - ycyc != SETTLE + 1) begin
      n_fail++;
      $display("FAIL jump_settle busy fell %0d cycles after Y strobe, want %0d", fall - ycyc, SETTLE + 1);
    end
    n_checks++;
    if (unblank != 0) begin
      n_fail++;
      $display("FAIL jump_blank got %0d unblanked cycles want 0", unblank);
    end
  endtask

  task automatic test_draw();
    bit ok;
    int s0;
    apply_reset();
    push_cmd(1'b1, 12'd10, 12'd0, 20, ok);
    wait_idle(3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL draw_timeout busy %b want 0", busy); end
    n_checks++;
    if (got_ls.size() != 1 || got_ls[0] !== {12'd0, 12'd0, 12'd10, 12'd0}) begin
      n_fail++;
      $display("FAIL draw_line_start got %0d starts %p want one (0,0)->(10,0)", got_ls.size(), got_ls);
    end
    n_checks++;
    if (got_dac.size() != 22) begin
      n_fail++;
      $display("FAIL draw_strobe_count got %0d want 22", got_dac.size());
    end
    for (int i = 0; i < got_dac.size() && i < exp_dac.size(); i++) begin
      n_checks++;
      if (got_dac[i] !== exp_dac[i] || got_dac[i][CW] !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL draw_dac[%0d] got %h want %h", i, got_dac[i], exp_dac[i]);
      end
    end
    s0 = strobe_cnt;
    push_cmd(1'b0, 12'd10, 12'd0, 20, ok);
    repeat (12) @(negedge clk);
    n_checks++;
    if (strobe_cnt != s0) begin
      n_fail++;
      $display("FAIL draw_end_pos got %0d strobes on jump to (10,0) want 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_dac_stall();
    bit ok;
    int s0, s1, a1;
    got_dac.delete(); exp_dac.delete(); got_ls.delete(); exp_ls.delete();
    s0 = strobe_cnt;
    push_cmd(1'b1, 12'd40, 12'd20, 20, ok);
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (dac_strobe && !dac_axis && strobe_cnt >= s0 + 4) begin stall_dac = 1'b1; ok = 1; break; end
    end
    @(posedge clk);
    s1 = strobe_cnt; a1 = acc_cnt;
    repeat (50) @(negedge clk);
    n_checks++;
    if (!ok || strobe_cnt != s1 || acc_cnt != a1) begin
      n_fail++;
      $display("FAIL stall_activity got %0d strobes %0d accepts (reached %0d) want 0 0", strobe_cnt - s1, acc_cnt - a1, ok);
    end
    stall_dac = 1'b0;
    wait_idle(3000, ok);
    n_checks++;
    if (!ok || got_dac.size() != exp_dac.size() || got_ls.size() != exp_ls.size()) begin
      n_fail++;
      $display("FAIL stall_resume got %0d writes %0d lines want %0d %0d", got_dac.size(), got_ls.size(), exp_dac.size(), exp_ls.size());
    end
    for (int i = 0; i < got_dac.size() && i < exp_dac.size(); i++) begin
      n_checks++;
      if (got_dac[i] !== exp_dac[i]) begin
        n_fail++;
        $display("FAIL stall_dac[%0d] got %h want %h", i, got_dac[i], exp_dac[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k, x, y, lost;
    logic d;
    got_dac.delete(); exp_dac.delete(); got_ls.delete(); exp_ls.delete();
    lost = 0;
    for (int c = 0; c < 30; c++) begin
      k = $urandom_range(0, 3);
      d = (c == 0) || (k < 2);
      if (d) begin
        x = (c == 0) ? int'(m_cur_x) : int'(m_cur_x) + $urandom_range(0, 16) - 8;
        y = (c == 0) ? int'(m_cur_y) : int'(m_cur_y) + $urandom_range(0, 16) - 8;
        x = (x < 0) ? 0 : (x > 4095) ? 4095 : x;
        y = (y < 0) ? 0 : (y > 4095) ? 4095 : y;
      end else if (k == 2) begin
        x = m_cur_x; y = m_cur_y;
      end else begin
        x = $urandom_range(0, 4095); y = $urandom_range(0, 4095);
      end
      push_cmd(d, CW'(x), CW'(y), 3000, ok);
      if (!ok) lost++;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    wait_idle(5000, ok);
    n_checks++;
    if (!ok || lost != 0) begin
      n_fail++;
      $display("FAIL b2b_drain idle %0d lost pushes %0d want 1 0", ok, lost);
    end
    n_checks++;
    if (got_dac.size() != exp_dac.size() || got_ls.size() != exp_ls.size()) begin
      n_fail++;
      $display("FAIL b2b_counts got %0d writes %0d lines want %0d %0d", got_dac.size(), got_ls.size(), exp_dac.size(), exp_ls.size());
    end
    for (int i = 0; i < got_dac.size() && i < exp_dac.size(); i++) begin
      n_checks++;
      if (got_dac[i] !== exp_dac[i]) begin
        n_fail++;
        $display("FAIL b2b_dac[%0d] got %h want %h", i, got_dac[i], exp_dac[i]);
      end
    end
    for (int i = 0; i < got_ls.size() && i < exp_ls.size(); i++) begin
      n_checks++;
      if (got_ls[i] !== exp_ls[i]) begin
        n_fail++;
        $display("FAIL b2b_line[%0d] got %h want %h", i, got_ls[i], exp_ls[i]);
      end
    end
    n_checks++;
    if (viol_cnt != 0) begin
      n_fail++;
      $display("FAIL dac_protocol got %0d strobes with dac_ready low want 0", viol_cnt);
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int acc, s0;
    stall_dac = 1'b1;
    repeat (6) @(posedge clk);
    s0 = strobe_cnt;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      push_cmd(1'b0, CW'((i + 1) * 7), CW'((i + 1) * 13), 10, ok);
      if (ok) acc++;
    end
    @(negedge clk);
    n_checks++;
    if (acc != DEPTH + 1 || cmd_ready !== 1'b0 || busy !== 1'b1 || strobe_cnt != s0) begin
      n_fail++;
      $display("FAIL fifo_full accepted %0d ready %b busy %b strobes %0d want %0d 0 1 0",
               acc, cmd_ready, busy, strobe_cnt - s0, DEPTH + 1);
    end
    apply_reset();
    stall_dac = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, blank, dac_strobe, dac_axis, line_start, line_pt_ready} !== 7'b1010000 ||
        {dac_value, line_x0, line_y0, line_x1, line_y1} !== '0) begin
      n_fail++;
      $display("FAIL full_reset got ctrl %b data %h want 1010000 0",
               {cmd_ready, busy, blank, dac_strobe, dac_axis, line_start, line_pt_ready},
               {dac_value, line_x0, line_y0, line_x1, line_y1});
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (got_dac.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flush got %0d writes busy %b after reset want 0 0", got_dac.size(), busy);
    end
  endtask

  task automatic test_reset_mid_draw();
    bit ok;
    int s0;
    s0 = strobe_cnt;
    push_cmd(1'b1, 12'd60, 12'd0, 20, ok);
    push_cmd(1'b0, 12'd500, 12'd500, 20, ok);
    push_cmd(1'b1, 12'd505, 12'd501, 20, ok);
    push_cmd(1'b0, 12'd9, 12'd9, 20, ok);
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (strobe_cnt >= s0 + 6) begin ok = 1; break; end
    end
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!ok || blank !== 1'b1 || busy !== 1'b0 || line_pt_ready !== 1'b0 || dac_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset got blank %b busy %b pt_ready %b strobe %b (reached %0d) want 1 0 0 0",
               blank, busy, line_pt_ready, dac_strobe, ok);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    got_dac.delete(); got_ls.delete(); exp_dac.delete(); exp_ls.delete();
    m_cur_x = '0; m_cur_y = '0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (got_dac.size() != 0 || got_ls.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_replay got %0d writes %0d lines busy %b want 0 0 0", got_dac.size(), got_ls.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_null_jump();
    test_jump();
    test_draw();
    test_dac_stall();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
